// File: rtl/tbird_pkg.sv
// ============================================================================
// Module : tbird_pkg
// Brief  : Shared state encoding, lamp patterns and helpers for the T-Bird
//          tail-light scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tbird_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_L1      = 4'd1,
      ST_L2      = 4'd2,
      ST_L3      = 4'd3,
      ST_R1      = 4'd4,
      ST_R2      = 4'd5,
      ST_R3      = 4'd6,
      ST_HAZ_ON  = 4'd7,
      ST_HAZ_OFF = 4'd8
   } state_t;

   // Debounced input vector layout
   localparam int IDX_LEFT  = 0;
   localparam int IDX_RIGHT = 1;
   localparam int IDX_HAZ   = 2;
   localparam int IDX_BRAKE = 3;
   localparam int NUM_REQ   = 4;

   localparam logic [5:0] PAT_OFF    = 6'b000000;
   localparam logic [5:0] PAT_ALL    = 6'b111111;
   localparam logic [5:0] PAT_L1     = 6'b001000;
   localparam logic [5:0] PAT_L2     = 6'b011000;
   localparam logic [5:0] PAT_L3     = 6'b111000;
   localparam logic [5:0] PAT_R1     = 6'b000100;
   localparam logic [5:0] PAT_R2     = 6'b000110;
   localparam logic [5:0] PAT_R3     = 6'b000111;
   localparam logic [5:0] LEFT_MASK  = 6'b111000;
   localparam logic [5:0] RIGHT_MASK = 6'b000111;

   // Brake lights the half not used by the running turn sequence
   function automatic logic [5:0] lamp_pattern(input state_t s, input logic brake);
      logic [5:0] p;
      p = PAT_OFF;
      case (s)
         ST_L1:     p = PAT_L1;
         ST_L2:     p = PAT_L2;
         ST_L3:     p = PAT_L3;
         ST_R1:     p = PAT_R1;
         ST_R2:     p = PAT_R2;
         ST_R3:     p = PAT_R3;
         ST_HAZ_ON: p = PAT_ALL;
         default:   p = PAT_OFF;
      endcase
      if (brake) begin
         case (s)
            ST_IDLE:             p = PAT_ALL;
            ST_L1, ST_L2, ST_L3: p = p | RIGHT_MASK;
            ST_R1, ST_R2, ST_R3: p = p | LEFT_MASK;
            default:             p = p;
         endcase
      end
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tbird_tick_div.sv
// ============================================================================
// Module : tbird_tick_div
// Brief  : Free-running divider producing a one-cycle step strobe every
//          SYSTEM_FREQ/HZ clocks; strobe is high while the counter is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tbird_tick_div #(
   parameter int SYSTEM_FREQ = 12500,
   parameter int HZ          = 8
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int PERIOD = SYSTEM_FREQ / HZ;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(PERIOD - 1)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tbird_signal_scheduler.sv
// ============================================================================
// Module : tbird_signal_scheduler
// Brief  : Synchronises/debounces turn, hazard and brake switches and
//          sequences the six tail lamps on a divided tick.
//          Option macro: TBIRD_LANE_CHANGE_EN (tap-to-flash lane change).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tbird_signal_scheduler
   import tbird_pkg::*;
#(
   parameter int SYSTEM_FREQ     = 12500,
   parameter int HZ              = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LANE_FLASHES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_req,
   input  logic       right_req,
   input  logic       haz_req,
   input  logic       brake_req,
   output logic [5:0] lights,
   output logic       active,
   output logic       tick
);

   localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [NUM_REQ-1:0] w_raw;
   logic [NUM_REQ-1:0] w_deb;
   logic               w_tick;
   logic               w_req_left;
   logic               w_req_right;
   state_t             r_state;
   state_t             w_state_next;

   assign w_raw = {brake_req, haz_req, right_req, left_req};

   tbird_tick_div #(
      .SYSTEM_FREQ (SYSTEM_FREQ),
      .HZ          (HZ)
   ) u_tick_div (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   assign tick = w_tick;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_debounce
      logic           r_sync1;
      logic           r_sync2;
      logic           r_deb;
      logic [DCW-1:0] r_cnt;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_sync1 <= w_raw[gi];
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
               r_cnt <= '0;
            end else if (r_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_deb[gi] = r_deb;
   end

`ifdef TBIRD_LANE_CHANGE_EN
   localparam int LCW = $clog2(LANE_FLASHES + 1);

   logic [LCW-1:0] r_lane_cnt;
   logic           r_lane_dir;   // 0 = left, 1 = right
   logic [1:0]     r_deb_prev;
   logic           w_rise_left;
   logic           w_rise_right;
   logic           w_seq_done;
   logic           w_enter_haz;

   assign w_rise_left  = w_deb[IDX_LEFT]  & ~r_deb_prev[0];
   assign w_rise_right = w_deb[IDX_RIGHT] & ~r_deb_prev[1];
   assign w_seq_done   = w_tick && (w_state_next == ST_IDLE) &&
                         ((r_state == ST_L3) || (r_state == ST_R3));
   assign w_enter_haz  = w_tick && (w_state_next == ST_HAZ_ON);

   assign w_req_left  = w_deb[IDX_LEFT]  | ((r_lane_cnt != '0) && !r_lane_dir);
   assign w_req_right = w_deb[IDX_RIGHT] | ((r_lane_cnt != '0) &&  r_lane_dir);

   // Hazard entry wins over a same-cycle tap; a fresh tap wins over a decrement
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lane_cnt <= '0;
         r_lane_dir <= 1'b0;
         r_deb_prev <= 2'b00;
      end else begin
         r_deb_prev <= {w_deb[IDX_RIGHT], w_deb[IDX_LEFT]};
         if (w_enter_haz) begin
            r_lane_cnt <= '0;
         end else if (w_rise_left) begin
            r_lane_cnt <= LCW'(LANE_FLASHES);
            r_lane_dir <= 1'b0;
         end else if (w_rise_right) begin
            r_lane_cnt <= LCW'(LANE_FLASHES);
            r_lane_dir <= 1'b1;
         end else if (w_seq_done && (r_lane_cnt != '0)) begin
            r_lane_cnt <= r_lane_cnt - 1'b1;
         end
      end
   end
`else
   assign w_req_left  = w_deb[IDX_LEFT];
   assign w_req_right = w_deb[IDX_RIGHT];

   if (LANE_FLASHES > 0) begin : g_lane_unused
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (w_deb[IDX_HAZ] || (w_req_left && w_req_right)) w_state_next = ST_HAZ_ON;
               else if (w_req_left)                               w_state_next = ST_L1;
               else if (w_req_right)                              w_state_next = ST_R1;
               else                                               w_state_next = ST_IDLE;
            end
            ST_L1:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_L2;
            ST_L2:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_L3;
            ST_L3:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_IDLE;
            ST_R1:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_R2;
            ST_R2:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_R3;
            ST_R3:      w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_IDLE;
            ST_HAZ_ON:  w_state_next = ST_HAZ_OFF;
            ST_HAZ_OFF: w_state_next = w_deb[IDX_HAZ] ? ST_HAZ_ON : ST_IDLE;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lights <= PAT_OFF;
         active <= 1'b0;
      end else begin
         lights <= lamp_pattern(r_state, w_deb[IDX_BRAKE]);
         active <= (r_state != ST_IDLE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tbird_signal_scheduler.sv
// ============================================================================
// Module : tb_tbird_signal_scheduler
// Brief  : Directed scenarios plus random switch activity checked against a
//          mode/step reference model of the tail-light scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tbird_signal_scheduler;

   localparam int PERIOD = 8;   // SYSTEM_FREQ / HZ
   localparam int DEB    = 2;
   localparam int FLASH  = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       left_req, right_req, haz_req, brake_req;
   logic [5:0] lights;
   logic       active;
   logic       tick;

   int n_chk = 0;
   int n_err = 0;

   tbird_signal_scheduler #(
      .SYSTEM_FREQ     (8),
      .HZ              (1),
      .DEBOUNCE_CYCLES (DEB),
      .LANE_FLASHES    (FLASH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .left_req  (left_req),
      .right_req (right_req),
      .haz_req   (haz_req),
      .brake_req (brake_req),
      .lights    (lights),
      .active    (active),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; step = lamps lit / hazard phase
   int   m_s1 [4], m_s2 [4], m_deb [4], m_run [4];
   int   m_cnt, m_mode, m_step, m_lane, m_dir;
   int   m_prev [2];
   logic [5:0] m_lights;
   logic       m_active;

   logic [5:0] last_lights;
   logic [5:0] obs [$];

   function automatic logic [5:0] model_pattern(input int mode, input int step, input int brake);
      int p;
      case (mode)
         1:       p = ((1 << step) - 1) << 3;
         2:       p = ((1 << step) - 1) << (3 - step);
         3:       p = (step == 1) ? 63 : 0;
         default: p = 0;
      endcase
      if (brake != 0) begin
         if (mode == 0)      p = 63;
         else if (mode == 1) p = p | 7;
         else if (mode == 2) p = p | 56;
      end
      return p[5:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
      end
      m_prev[0] = 0; m_prev[1] = 0;
      m_cnt = 0; m_mode = 0; m_step = 0; m_lane = 0; m_dir = 0;
      m_lights = '0; m_active = 1'b0;
   endtask

   task automatic model_clock();
      int in_v [4];
      int L, R, H, B, effL, effR, nmode, nstep, done, haz_entry;
      bit tk;
      in_v[0] = int'(left_req); in_v[1] = int'(right_req);
      in_v[2] = int'(haz_req);  in_v[3] = int'(brake_req);
      if (reset) begin
         model_reset();
         return;
      end
      L = m_deb[0]; R = m_deb[1]; H = m_deb[2]; B = m_deb[3];
      tk = (m_cnt == 0);
      m_lights = model_pattern(m_mode, m_step, B);
      m_active = (m_mode != 0);
      effL = L; effR = R;
`ifdef TBIRD_LANE_CHANGE_EN
      if (m_lane > 0 && m_dir == 0) effL = 1;
      if (m_lane > 0 && m_dir == 1) effR = 1;
`endif
      nmode = m_mode; nstep = m_step; done = 0; haz_entry = 0;
      if (tk) begin
         if (m_mode == 0) begin
            if (H != 0 || (effL != 0 && effR != 0)) begin nmode = 3; nstep = 1; end
            else if (effL != 0) begin nmode = 1; nstep = 1; end
            else if (effR != 0) begin nmode = 2; nstep = 1; end
         end else if (m_mode == 3) begin
            if (m_step == 1)  nstep = 0;
            else if (H != 0)  nstep = 1;
            else begin nmode = 0; nstep = 0; end
         end else begin
            if (H != 0)            begin nmode = 3; nstep = 1; end
            else if (m_step == 3)  begin nmode = 0; nstep = 0; done = 1; end
            else                   nstep = m_step + 1;
         end
         haz_entry = (nmode == 3 && nstep == 1) ? 1 : 0;
      end
`ifdef TBIRD_LANE_CHANGE_EN
      if (haz_entry != 0)                 m_lane = 0;
      else if (L != 0 && m_prev[0] == 0) begin m_lane = FLASH; m_dir = 0; end
      else if (R != 0 && m_prev[1] == 0) begin m_lane = FLASH; m_dir = 1; end
      else if (done != 0 && m_lane > 0)  m_lane = m_lane - 1;
      m_prev[0] = L; m_prev[1] = R;
`endif
      m_mode = nmode; m_step = nstep;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_deb[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
         end else begin
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = in_v[i];
      end
      m_cnt = (m_cnt + 1) % PERIOD;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock: update model, sample DUT 1ns after the edge, compare, log lamp changes
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_clock();
         #1;
         check("lights", 32'(lights), 32'(m_lights));
         check("active", 32'(active), 32'(m_active));
         check("tick",   32'(tick),   32'(m_cnt == 0));
         if (lights !== last_lights) obs.push_back(lights);
         last_lights = lights;
      end
   endtask

   task automatic set_req(input logic l, input logic r, input logic h, input logic b);
      left_req = l; right_req = r; haz_req = h; brake_req = b;
   endtask

   task automatic do_reset(input int n);
      set_req(0, 0, 0, 0);
      reset = 1'b1;
      step(n);
      reset = 1'b0;
      obs.delete();
   endtask

   task automatic wait_lights(input logic [5:0] val, input int max_cyc);
      int k;
      k = 0;
      while (lights !== val && k < max_cyc) begin
         step(1);
         k++;
      end
      check("wait_lights", 32'(lights), 32'(val));
   endtask

   initial begin
      int cnt_l3;
      reset = 1'b1;
      set_req(0, 0, 0, 0);
      model_reset();
      last_lights = '0;

      // 1: reset held, quiet inputs
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("rst_lights", 32'(lights), 32'h0);
         check("rst_active", 32'(active), 32'h0);
      end
      reset = 1'b0;
      step(12);
      check("post_rst_lights", 32'(lights), 32'h0);
      check("post_rst_active", 32'(active), 32'h0);

      // 2: left held cycles through the left sequence
      do_reset(3);
      set_req(1, 0, 0, 0);
      step(48);
      check("left_seq0", 32'(obs[0]), 32'h08);
      check("left_seq1", 32'(obs[1]), 32'h18);
      check("left_seq2", 32'(obs[2]), 32'h38);
      check("left_seq3", 32'(obs[3]), 32'h00);

      // 3: hazard preempts L2, then flashes, then returns idle
      do_reset(3);
      set_req(1, 0, 0, 0);
      wait_lights(6'b011000, 64);
      set_req(1, 0, 1, 0);
      obs.delete();
      step(24);
      check("haz_pre0", 32'(obs[0]), 32'h3F);
      check("haz_pre1", 32'(obs[1]), 32'h00);
      check("haz_pre2", 32'(obs[2]), 32'h3F);
      set_req(0, 0, 0, 0);
      step(30);
      check("haz_end_lights", 32'(lights), 32'h0);
      check("haz_end_active", 32'(active), 32'h0);

      // 4: simultaneous left and right means hazard
      do_reset(3);
      set_req(1, 1, 0, 0);
      step(20);
      check("lr_haz", 32'(obs[0]), 32'h3F);

      // 5: brake overlay
      do_reset(3);
      set_req(0, 0, 0, 1);
      step(10);
      check("brake_idle", 32'(lights), 32'h3F);
      obs.delete();
      set_req(0, 1, 0, 1);
      step(40);
      check("brake_r1", 32'(obs[0]), 32'h3C);
      check("brake_r2", 32'(obs[1]), 32'h3E);
      check("brake_r3", 32'(obs[2]), 32'h3F);

      // 6a: single-cycle glitch is filtered
      do_reset(3);
      set_req(1, 0, 0, 0);
      step(1);
      set_req(0, 0, 0, 0);
      step(30);
      check("glitch_changes", 32'(obs.size()), 32'd0);
      check("glitch_lights", 32'(lights), 32'h0);

      // 6b: three-cycle tap right after reset release
      do_reset(3);
      set_req(1, 0, 0, 0);
      step(3);
      set_req(0, 0, 0, 0);
`ifdef TBIRD_LANE_CHANGE_EN
      step(130);
      cnt_l3 = 0;
      foreach (obs[i]) if (obs[i] == 6'b111000) cnt_l3++;
      check("lane_l3_count", 32'(cnt_l3), 32'd3);
`else
      step(40);
      check("tap_changes", 32'(obs.size()), 32'd0);
`endif
      check("tap_lights", 32'(lights), 32'h0);
      check("tap_active", 32'(active), 32'h0);

      // Random switch activity against the model
      do_reset(2);
      for (int b = 0; b < 120; b++) begin
         logic [3:0] r;
         r = 4'($urandom);
         set_req(r[0], r[1], ($urandom_range(0, 3) == 0), r[3]);
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b1;
            step($urandom_range(1, 2));
            reset = 1'b0;
         end
         step($urandom_range(1, 24));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, observed=running expected=done");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
